// File: rtl/qm_pkg.sv
// Shared types and elaboration-time helpers for the queue manager.
//   qm_state_e : wait-time FSM states (IDLE, CALC)
//   clog2      : ceiling log2, clog2(1) = 0
//   num_width  : width of the wait-time numerator SVC_TIME*(pcount+tcount-1)
//   saturate   : clamp a value to the all-ones maximum of a given width
package qm_pkg;

    typedef enum logic [0:0] {IDLE, CALC} qm_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    // Largest numerator is SVC_TIME*(CAPACITY + max_tcount - 1).
    function automatic int unsigned num_width(input int unsigned svc_time,
                                              input int unsigned capacity,
                                              input int unsigned teller_w);
        return clog2(svc_time * (capacity + (32'd1 << teller_w) - 2) + 1);
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] value,
                                             input int unsigned width);
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        if ({1'b0, value} > max_val) return max_val[31:0];
        return value;
    endfunction

endpackage

// File: rtl/qm_divider.sv
// Restoring sequential unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : load num/den and begin; also aborts and restarts a running division
//   num, den    : dividend (NUM_W bits) and divisor (DEN_W bits)
//   busy        : division in progress
//   done        : high in the cycle whose closing edge produces the last quotient bit
//   quo         : quotient, valid while done is high
module qm_divider
    import qm_pkg::*;
#(
    parameter int unsigned NUM_W = 5,
    parameter int unsigned DEN_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    localparam int unsigned CW = clog2(NUM_W + 1);

    logic [NUM_W-1:0] dividend_q;
    logic [NUM_W-1:0] quo_q;
    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [DEN_W:0]   trial;
    logic             fits;
    logic [DEN_W:0]   rem_next;
    logic [NUM_W-1:0] quo_next;

    // Remainder is always below the divisor, so DEN_W bits hold it between steps.
    always_comb begin
        trial    = {rem_q, dividend_q[NUM_W-1]};
        fits     = trial >= {1'b0, den_q};
        rem_next = fits ? (trial - {1'b0, den_q}) : trial;
        quo_next = (quo_q << 1) | NUM_W'(fits);
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    assign quo  = quo_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_q <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else if (start) begin
            dividend_q <= num;
            quo_q      <= '0;
            rem_q      <= '0;
            den_q      <= den;
            cnt_q      <= CW'(NUM_W);
            busy_q     <= 1'b1;
        end else if (busy_q) begin
            dividend_q <= dividend_q << 1;
            quo_q      <= quo_next;
            rem_q      <= rem_next[DEN_W-1:0];
            cnt_q      <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/queue_manager_param.sv
// Single-queue people counter with expected-wait-time estimate.
// Optional macro QM_DEBOUNCE_EN: debounce each photocell for DEB_CYCLES cycles
// (low to fire, high to re-arm) instead of raw two-register edge detection.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   back_pc     : entry photocell, active-low; falling edge = arrival
//   front_pc    : exit photocell, active-low; falling edge = departure
//   tcount      : active tellers (0 = closed)
//   pcount      : queue length, saturating at CAPACITY
//   full, empty : pcount == CAPACITY / pcount == 0
//   wtime       : floor(SVC_TIME*(pcount+tcount-1)/tcount), saturated; 0 if empty,
//                 all-ones if closed with people waiting
//   wtime_valid : wtime matches the current pcount/tcount
//   ovf_err     : sticky, an arrival was dropped while full
//   udf_err     : sticky, a departure was seen while empty
module queue_manager_param
    import qm_pkg::*;
#(
    parameter int unsigned CAPACITY   = 7,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned TELLER_W   = 2,
    parameter int unsigned SVC_TIME   = 3,
    parameter int unsigned WTIME_W    = 5,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                back_pc,
    input  logic                front_pc,
    input  logic [TELLER_W-1:0] tcount,
    output logic [CNT_W-1:0]    pcount,
    output logic                full,
    output logic                empty,
    output logic [WTIME_W-1:0]  wtime,
    output logic                wtime_valid,
    output logic                ovf_err,
    output logic                udf_err
);

    localparam int unsigned NUM_W = num_width(SVC_TIME, CAPACITY, TELLER_W);

    // ---------------- photocell event detection ----------------
    logic back_s1, front_s1;
    logic arr, dep;

`ifdef QM_DEBOUNCE_EN
    localparam int unsigned DEB_W = clog2(DEB_CYCLES + 1);

    logic [1:0]       s1_vec;
    logic [1:0]       armed_q;
    logic [1:0]       fall_vec;
    logic [DEB_W-1:0] deb_cnt_q [2];

    assign s1_vec = {front_s1, back_s1};

    always_ff @(posedge clk) begin
        if (reset) begin
            back_s1  <= 1'b1;
            front_s1 <= 1'b1;
        end else begin
            back_s1  <= back_pc;
            front_s1 <= front_pc;
        end
    end

    // Fire on the DEB_CYCLES-th consecutive low sample while armed.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fall_vec[i] = armed_q[i] & ~s1_vec[i] & (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 2'b11;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (armed_q[i]) begin
                    if (s1_vec[i]) begin
                        deb_cnt_q[i] <= '0;
                    end else if (fall_vec[i]) begin
                        armed_q[i]   <= 1'b0;
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    if (!s1_vec[i]) begin
                        deb_cnt_q[i] <= '0;
                    end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        armed_q[i]   <= 1'b1;
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                    end
                end
            end
        end
    end

    assign arr = fall_vec[0];
    assign dep = fall_vec[1];
`else
    logic back_s2, front_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            back_s1  <= 1'b1;
            back_s2  <= 1'b1;
            front_s1 <= 1'b1;
            front_s2 <= 1'b1;
        end else begin
            back_s1  <= back_pc;
            back_s2  <= back_s1;
            front_s1 <= front_pc;
            front_s2 <= front_s1;
        end
    end

    assign arr = back_s2 & ~back_s1;
    assign dep = front_s2 & ~front_s1;
`endif

    // ---------------- queue counter ----------------
    logic [CNT_W-1:0] pcount_q;
    logic             ovf_q, udf_q;

    assign full  = (pcount_q == CNT_W'(CAPACITY));
    assign empty = (pcount_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcount_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (arr && !dep) begin
            if (full) ovf_q <= 1'b1;
            else      pcount_q <= pcount_q + CNT_W'(1);
        end else if (dep && !arr) begin
            if (empty) udf_q <= 1'b1;
            else       pcount_q <= pcount_q - CNT_W'(1);
        end
    end

    assign pcount  = pcount_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

    // ---------------- wait-time FSM ----------------
    qm_state_e         state_q, state_d;
    logic [CNT_W-1:0]    snap_p_q, snap_p_d;
    logic [TELLER_W-1:0] snap_t_q, snap_t_d;
    logic [WTIME_W-1:0]  wtime_q, wtime_d;

    logic              changed, zero_case;
    logic [WTIME_W-1:0] zero_wtime;
    logic [31:0]       num_wide;
    logic [31:0]       sat_quo;
    logic              div_start, div_busy, div_done;
    logic [NUM_W-1:0]  div_quo;

    assign changed    = (pcount_q != snap_p_q) || (tcount != snap_t_q);
    assign zero_case  = (pcount_q == '0) || (tcount == '0);
    assign zero_wtime = (pcount_q == '0) ? '0 : '1;
    // Only meaningful when both operands are non-zero.
    assign num_wide   = SVC_TIME * (32'(pcount_q) + 32'(tcount) - 32'd1);
    assign sat_quo    = saturate(32'(div_quo), WTIME_W);

    qm_divider #(
        .NUM_W (NUM_W),
        .DEN_W (TELLER_W)
    ) u_divider (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   (num_wide[NUM_W-1:0]),
        .den   (tcount),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        snap_p_d  = snap_p_q;
        snap_t_d  = snap_t_q;
        wtime_d   = wtime_q;
        div_start = 1'b0;
        if (changed) begin
            // New snapshot; in CALC this aborts the running division.
            snap_p_d = pcount_q;
            snap_t_d = tcount;
            if (zero_case) begin
                wtime_d = zero_wtime;
                state_d = IDLE;
            end else begin
                div_start = 1'b1;
                state_d   = CALC;
            end
        end else if ((state_q == CALC) && div_done) begin
            wtime_d = sat_quo[WTIME_W-1:0];
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            snap_p_q <= '0;
            snap_t_q <= '0;
            wtime_q  <= '0;
        end else begin
            state_q  <= state_d;
            snap_p_q <= snap_p_d;
            snap_t_q <= snap_t_d;
            wtime_q  <= wtime_d;
        end
    end

    assign wtime       = wtime_q;
    assign wtime_valid = (state_q == IDLE);

endmodule

// File: tb/tb_queue_manager_param.sv
// Bench for queue_manager_param (default build, debounce disabled).
module tb_queue_manager_param;

    localparam int unsigned CAPACITY   = 7;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned TELLER_W   = 2;
    localparam int unsigned SVC_TIME   = 3;
    localparam int unsigned WTIME_W    = 5;
    localparam int unsigned DEB_CYCLES = 4;
    // ceil(log2(3*(7+4-2)+1)) = ceil(log2(28)) = 5
    localparam int unsigned NUM_W      = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                back_pc;
    logic                front_pc;
    logic [TELLER_W-1:0] tcount;
    logic [CNT_W-1:0]    pcount;
    logic                full;
    logic                empty;
    logic [WTIME_W-1:0]  wtime;
    logic                wtime_valid;
    logic                ovf_err;
    logic                udf_err;

    queue_manager_param #(
        .CAPACITY   (CAPACITY),
        .CNT_W      (CNT_W),
        .TELLER_W   (TELLER_W),
        .SVC_TIME   (SVC_TIME),
        .WTIME_W    (WTIME_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .back_pc     (back_pc),
        .front_pc    (front_pc),
        .tcount      (tcount),
        .pcount      (pcount),
        .full        (full),
        .empty       (empty),
        .wtime       (wtime),
        .wtime_valid (wtime_valid),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int exp_p   = 0;
    bit exp_ovf = 1'b0;
    bit exp_udf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_wtime(input int p, input int t);
        int w;
        int max_w;
        max_w = (1 << WTIME_W) - 1;
        if (p == 0) return 0;
        if (t == 0) return max_w;
        w = (SVC_TIME * (p + t - 1)) / t;
        return (w > max_w) ? max_w : w;
    endfunction

    task automatic model_event(input bit a, input bit d);
        if (a && !d) begin
            if (exp_p == CAPACITY) exp_ovf = 1'b1;
            else exp_p++;
        end else if (d && !a) begin
            if (exp_p == 0) exp_udf = 1'b1;
            else exp_p--;
        end
    endtask

    task automatic model_reset();
        exp_p   = 0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    // Drive selected photocells low for len cycles, then release.
    task automatic pulse(input bit b, input bit f, input int len);
        @(negedge clk);
        if (b) back_pc = 1'b0;
        if (f) front_pc = 1'b0;
        repeat (len) @(negedge clk);
        back_pc  = 1'b1;
        front_pc = 1'b1;
        model_event(b, f);
    endtask

    // Let the event reach pcount and the estimate settle, with a bounded wait.
    task automatic settle();
        int waited;
        waited = 0;
        repeat (4) @(negedge clk);
        while (wtime_valid !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("settle_valid", 32'(wtime_valid), 32'd1);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pcount"}, 32'(pcount), 32'(exp_p));
        check({tag, "_full"},   32'(full),   32'(exp_p == CAPACITY));
        check({tag, "_empty"},  32'(empty),  32'(exp_p == 0));
        check({tag, "_ovf"},    32'(ovf_err), 32'(exp_ovf));
        check({tag, "_udf"},    32'(udf_err), 32'(exp_udf));
        check({tag, "_wtime"},  32'(wtime),  32'(exp_wtime(exp_p, int'(tcount))));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int low_cycles;
        int r;

        reset    = 1'b1;
        back_pc  = 1'b1;
        front_pc = 1'b1;
        tcount   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pcount", 32'(pcount), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wtime", 32'(wtime), 32'd0);
        check("rst_valid", 32'(wtime_valid), 32'd1);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_udf", 32'(udf_err), 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check("post_rst_pcount", 32'(pcount), 32'd0);

        // Fill past capacity with three tellers
        tcount = 2'd3;
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0, 1);
            settle();
            check_all("fill");
        end
        check("fill_wtime9", 32'(wtime), 32'd9);

        // Drain past empty
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0, 1'b1, 1);
            settle();
            check_all("drain");
        end

        // Simultaneous arrival and departure; held-low input
        apply_reset();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1);
        settle();
        pulse(1'b1, 1'b1, 1);
        settle();
        check_all("both");
        pulse(1'b1, 1'b0, 10);
        settle();
        check_all("held");

        // Wait-time latency and special cases at pcount = 7
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1);
        settle();
        check_all("seven");
        @(negedge clk);
        tcount     = 2'd1;
        low_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wtime_valid === 1'b0) low_cycles++;
            else break;
        end
        check("calc_cycles", 32'(low_cycles), 32'(NUM_W));
        check("wtime_t1", 32'(wtime), 32'd21);
        tcount = 2'd0;
        settle();
        check("wtime_closed", 32'(wtime), 32'd31);
        tcount = 2'd3;
        repeat (2) @(negedge clk);
        tcount = 2'd2;
        @(negedge clk);
        check("restart_hold_wtime", 32'(wtime), 32'd31);
        check("restart_invalid", 32'(wtime_valid), 32'd0);
        settle();
        check_all("restart");

        // Reset in the middle of a division
        tcount = 2'd1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pcount", 32'(pcount), 32'd0);
        check("midrst_wtime", 32'(wtime), 32'd0);
        check("midrst_valid", 32'(wtime_valid), 32'd1);
        reset = 1'b0;
        model_reset();
        settle();
        check_all("midrst_after");

        // Randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: pulse(1'b1, 1'b0, $urandom_range(1, 3));
                1: pulse(1'b0, 1'b1, $urandom_range(1, 3));
                2: pulse(1'b1, 1'b1, $urandom_range(1, 3));
                default: tcount = TELLER_W'($urandom_range(0, 3));
            endcase
            settle();
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
